jt5205_feeder: RTL

Sample-rate and nibble feeder sitting directly upstream of the JT5205 ADPCM decoder. Accepts bytes from a host write port into a small FIFO, divides the master clock enable by the MSM5205-style prescaler selection, and on every sample tick presents the next 4-bit ADPCM code with a one-clock enable for the decoder. Also generates the VCK square wave and flags underruns.

---
 rtl/jt5205_feeder.sv | 130 +++++++++++++
 1 files changed

// File: rtl/jt5205_feeder.sv
// Byte FIFO, MSM5205-style prescaler and nibble sequencer feeding the JT5205 decoder.
// Each sample tick presents the next 4-bit code with a one-clock enable.
module jt5205_feeder #(
   parameter int unsigned FIFO_AW = 3
) (
   input  logic               rst,
   input  logic               clk,
   input  logic               cen,
   input  logic [1:0]         sel,
   input  logic               wr,
   input  logic [7:0]         wdata,
   output logic               full,
   output logic               empty,
   output logic [FIFO_AW:0]   level,
   output logic [3:0]         din,
   output logic               dout_cen,
   output logic               vclk,
   output logic               underrun
);

   localparam int unsigned DEPTH = 1 << FIFO_AW;
   localparam int unsigned CW    = 7;
   localparam int unsigned LW    = FIFO_AW + 1;

   logic [CW-1:0]      cnt_q, cnt_d;
   logic [1:0]         sel_q;
   logic               vclk_q, vclk_d;
   logic               hi_q, hi_d;
   logic [3:0]         din_q, din_d;
   logic               dout_cen_q, dout_cen_d;
   logic               underrun_q, underrun_d;
   logic [FIFO_AW-1:0] wp_q, wp_d, rp_q, rp_d;
   logic [LW-1:0]      count_q, count_d;
   logic [7:0]         mem_q [DEPTH];

   logic [CW-1:0]      n;
   logic               stopped, sel_chg, tick, have_data, push, pop;
   logic [7:0]         head;

   // Prescaler ratio for the current selection; 3 stops the clock entirely.
   always_comb begin
      n = CW'(96);
      case (sel)
         2'd0:    n = CW'(96);
         2'd1:    n = CW'(48);
         2'd2:    n = CW'(64);
         default: n = CW'(96);
      endcase
   end

   assign stopped   = (sel == 2'd3);
   assign sel_chg   = (sel != sel_q);
   assign tick      = cen & ~stopped & ~sel_chg & (cnt_q == n - CW'(1));
   assign have_data = (count_q != '0);
   assign head      = mem_q[rp_q];
   // Full is judged on the registered level, so a same-edge pop never rescues a write.
   assign push      = wr & (count_q != LW'(DEPTH));
   assign pop       = tick & have_data & ~hi_q;

   always_comb begin
      cnt_d      = cnt_q;
      hi_d       = hi_q;
      din_d      = din_q;
      dout_cen_d = tick;
      underrun_d = tick & ~have_data;
      wp_d       = wp_q;
      rp_d       = rp_q;
      count_d    = count_q + LW'(push) - LW'(pop);

      if (stopped || sel_chg) begin
         cnt_d = '0;
      end else if (cen) begin
         cnt_d = tick ? '0 : cnt_q + CW'(1);
      end

      if (tick) begin
         if (have_data) begin
            din_d = hi_q ? head[7:4] : head[3:0];
            hi_d  = ~hi_q;
         end else begin
            din_d = 4'd0;
         end
      end

      if (push) wp_d = wp_q + FIFO_AW'(1);
      if (pop)  rp_d = rp_q + FIFO_AW'(1);

      vclk_d = ~stopped & (cnt_d < (n >> 1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q      <= '0;
         sel_q      <= 2'd3;
         vclk_q     <= 1'b0;
         hi_q       <= 1'b1;
         din_q      <= 4'd0;
         dout_cen_q <= 1'b0;
         underrun_q <= 1'b0;
         wp_q       <= '0;
         rp_q       <= '0;
         count_q    <= '0;
      end else begin
         cnt_q      <= cnt_d;
         sel_q      <= sel;
         vclk_q     <= vclk_d;
         hi_q       <= hi_d;
         din_q      <= din_d;
         dout_cen_q <= dout_cen_d;
         underrun_q <= underrun_d;
         wp_q       <= wp_d;
         rp_q       <= rp_d;
         count_q    <= count_d;
      end
   end

   // Storage needs no reset: the pointers define which entries are live.
   always_ff @(posedge clk) begin
      if (push) mem_q[wp_q] <= wdata;
   end

   assign full     = (count_q == LW'(DEPTH));
   assign empty    = (count_q == '0);
   assign level    = count_q;
   assign din      = din_q;
   assign dout_cen = dout_cen_q;
   assign vclk     = vclk_q;
   assign underrun = underrun_q;

endmodule
